mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates one single-port, variable-latency unified memory between the fetch stage and the memory stage of the 5-stage pipeline.
- Serializes accesses and holds each request stable until the memory handshakes.
- Returns read data and one-cycle valid pulses, and drives per-stage stall signals to the hazard logic.
- Data accesses take priority; a one-cycle lockout of the just-served port guarantees fetch progress.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, maximum wait cycles for mem_ready before abort (must be ≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- PCF  in  AW  fetch address
- IFReq  in  1  fetch request, held until IFValid
- InstrF  out  DW  fetched instruction (registered)
- IFValid  out  1  one-cycle pulse, InstrF valid
- DataReqM  in  1  data request, held until DataValidM
- MemWriteM  in  1  1 = write, 0 = read
- ALUResultM  in  AW  data address
- WriteDataM  in  DW  store data
- ReadDataM  out  DW  load data (registered)
- DataValidM  out  1  one-cycle pulse, data access complete
- StallF  out  1  fetch stage must hold
- StallM  out  1  memory stage must hold
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory completion, 1 cycle
- BusErr  out  1  sticky timeout flag

Behaviour:
- Reset (async, reset=0): state IDLE; mem_req, mem_we, IFValid, DataValidM, BusErr = 0; InstrF, ReadDataM, mem_addr, mem_wdata = 0; wait counter = 0.
- States: IDLE, IFETCH, DACCESS.
- Eligibility: a port is eligible when its request is high and its own valid output is low in the same cycle. This lockout prevents double-issue while the requester still holds the old request.
- IDLE:
  - If data is eligible, latch ALUResultM, WriteDataM and MemWriteM, then go to DACCESS.
  - Else if fetch is eligible, latch PCF with we=0, then go to IFETCH.
  - Else stay in IDLE.
- IFETCH / DACCESS:
  - mem_req = 1; mem_addr, mem_we and mem_wdata come from the latches and stay stable until completion.
  - Completion is a cycle in which mem_ready = 1. On completion:
    - Fetch: InstrF <= mem_rdata; IFValid = 1 next cycle.
    - Data read: ReadDataM <= mem_rdata.
    - Data write: ReadDataM unchanged.
    - Data (read or write): DataValidM = 1 next cycle.
    - State returns to IDLE.
- Minimum latency: request sampled in IDLE at cycle N, mem_ready at N+1, valid at N+2.
- Valid pulses last exactly one cycle.
- Wait counter:
  - Increments on each cycle with mem_req=1 and mem_ready=0; clears on completion or abort.
  - When the counter reaches TIMEOUT with no mem_ready, abort: go to IDLE, pulse the port's valid with data 0, set BusErr=1.
  - BusErr is sticky until reset.
- Stalls (combinational): StallF = IFReq & ~IFValid; StallM = DataReqM & ~DataValidM.
- Simultaneous requests in IDLE: data wins. Fetch is served next, because data is locked out during its valid cycle.
- mem_ready outside IFETCH/DACCESS is ignored.
- A request dropped mid-access does not cancel the access; it completes and its valid still pulses.
- Async reset mid-access drops mem_req immediately. The memory side must tolerate an abandoned request.

Decomposition:
- Shared header mem_arb_defs: state encodings (IDLE=2'd0, IFETCH=2'd1, DACCESS=2'd2) and default widths.
- One sub-module, arb_wait_ctr: clear, increment and timeout compare, with TIMEOUT as a parameter.

Test Plan:
- Fetch only: IFReq=1, PCF=0x100, mem_ready 1 cycle after mem_req, rdata=0xE2811001 -> mem_addr=0x100, mem_we=0; IFValid pulses at N+2 with InstrF=0xE2811001; StallF high for 2 cycles.
- Simultaneous requests: IFReq=1, DataReqM=1 read 0x200 -> data served first (ReadDataM valid); fetch issued in the DataValidM cycle; no second data issue.
- Write with 3 wait cycles: MemWriteM=1, addr 0x40, wdata 0xDEADBEEF -> mem_addr, mem_we and mem_wdata stable for all 4 request cycles; DataValidM pulses once; ReadDataM unchanged.
- Timeout: mem_ready held 0 -> abort after 15 waiting cycles; valid pulses with data 0; BusErr=1 and stays 1 across later accesses.
- Reset mid-access: reset=0 during DACCESS -> mem_req=0 immediately and all outputs at reset values; after release, a held request re-issues cleanly.
- Back-to-back fetches: IFReq held, PCF 0x0 then 0x4 after IFValid -> two distinct accesses; no duplicate issue of 0x0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings and default widths for the memory arbiter
package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } arbState_t;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single-port memory bus between the arbiter (master) and the memory (slave)
interface mem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_arbiter_wait_ctr.sv
// arb_wait_ctr: counts unanswered request cycles and flags the one that exhausts the budget
module arb_wait_ctr #(parameter int TIMEOUT = 15) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic timeout
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    // Fires on the TIMEOUT-th waiting cycle, so the access is abandoned at that edge
    assign timeout = inc && cnt == W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr || timeout) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes fetch and data accesses onto one variable-latency memory port,
// data first, with a one-cycle lockout of the port whose valid is pulsing
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] PCF,
    input  logic          IFReq,
    output logic [DW-1:0] InstrF,
    output logic          IFValid,
    input  logic          DataReqM,
    input  logic          MemWriteM,
    input  logic [AW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          DataValidM,
    output logic          StallF,
    output logic          StallM,
    output logic          BusErr,
    mem_arbiter_if.master mem
);
    arbState_t state;
    logic timeout;
    logic dataElig;
    logic fetchElig;
    assign dataElig  = DataReqM & ~DataValidM;
    assign fetchElig = IFReq & ~IFValid;
    assign StallF = IFReq & ~IFValid;
    assign StallM = DataReqM & ~DataValidM;
    arb_wait_ctr #(.TIMEOUT(TIMEOUT)) waitCtr (
        .clk(clk),
        .reset(reset),
        .clr(mem.mem_req & mem.mem_ready),
        .inc(mem.mem_req & ~mem.mem_ready),
        .timeout(timeout)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            mem.mem_req <= 1'b0;
            mem.mem_we <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_wdata <= '0;
            InstrF <= '0;
            ReadDataM <= '0;
            IFValid <= 1'b0;
            DataValidM <= 1'b0;
            BusErr <= 1'b0;
        end else begin
            IFValid <= 1'b0;
            DataValidM <= 1'b0;
            case (state)
                IDLE: begin
                    if (dataElig) begin
                        mem.mem_req <= 1'b1;
                        mem.mem_we <= MemWriteM;
                        mem.mem_addr <= ALUResultM;
                        mem.mem_wdata <= WriteDataM;
                        state <= DACCESS;
                    end else if (fetchElig) begin
                        mem.mem_req <= 1'b1;
                        mem.mem_we <= 1'b0;
                        mem.mem_addr <= PCF;
                        state <= IFETCH;
                    end
                end
                IFETCH, DACCESS: begin
                    // An abort completes the access like a response, but with zero data
                    if (mem.mem_ready || timeout) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we <= 1'b0;
                        state <= IDLE;
                        if (!mem.mem_ready) BusErr <= 1'b1;
                        if (state == IFETCH) begin
                            IFValid <= 1'b1;
                            InstrF <= mem.mem_ready ? mem.mem_rdata : '0;
                        end else begin
                            DataValidM <= 1'b1;
                            if (!mem.mem_ready) ReadDataM <= '0;
                            else if (!mem.mem_we) ReadDataM <= mem.mem_rdata;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and a randomized run against a
// behavioural memory plus requester-side expectations
module tb_mem_arbiter;
    logic clk = 0;
    logic rstN = 0;
    logic [31:0] PCF = 0, ALUResultM = 0, WriteDataM = 0;
    logic IFReq = 0, DataReqM = 0, MemWriteM = 0;
    logic [31:0] InstrF, ReadDataM;
    logic IFValid, DataValidM, StallF, StallM, BusErr;
    int total = 0, bad = 0;
    mem_arbiter_if bus();
    mem_arbiter dut (
        .clk(clk), .reset(rstN), .PCF(PCF), .IFReq(IFReq), .InstrF(InstrF), .IFValid(IFValid),
        .DataReqM(DataReqM), .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadDataM(ReadDataM), .DataValidM(DataValidM), .StallF(StallF), .StallM(StallM),
        .BusErr(BusErr), .mem(bus.master)
    );
    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural memory: answers each request after a chosen number of wait cycles
    logic memOff = 0, tblMode = 1;
    logic [31:0] tblRdata = 0;
    int tblLat = 0, lat = 0, waitCnt = 0;
    logic [31:0] memArr [logic [31:0]];
    logic [31:0] lastAddr = 0, lastWdata = 0;
    logic lastWe = 0;
    logic [31:0] issued[$];
    function automatic logic [31:0] memRd(logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction
    initial begin
        bus.mem_ready = 0;
        bus.mem_rdata = 0;
    end
    always @(posedge clk) begin
        #1;
        if (!rstN) begin
            bus.mem_ready = 0;
            waitCnt = 0;
        end else if (bus.mem_ready) begin
            bus.mem_ready = 0;
            waitCnt = 0;
        end else if (bus.mem_req && !memOff) begin
            if (waitCnt >= (tblMode ? tblLat : lat)) begin
                bus.mem_ready = 1;
                lastAddr = bus.mem_addr;
                lastWe = bus.mem_we;
                lastWdata = bus.mem_wdata;
                issued.push_back(bus.mem_addr);
                bus.mem_rdata = tblMode ? tblRdata : (bus.mem_we ? $urandom : memRd(bus.mem_addr));
                if (bus.mem_we) memArr[bus.mem_addr] = bus.mem_wdata;
                lat = $urandom_range(0, 3);
                waitCnt = 0;
            end else waitCnt++;
        end
    end

    logic stallChk = 0;
    always @(negedge clk) if (stallChk)
        check("stalls", {30'd0, StallF, StallM}, {30'd0, IFReq & ~IFValid, DataReqM & ~DataValidM});

    typedef struct {
        logic isData;
        logic we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int lat;
        logic [31:0] expData;
        int expCyc;
    } vec_t;
    vec_t vecs[4];
    logic [31:0] lastRd;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, reqCyc, dv, nv, n0;
        logic got, stable;
        vecs[0] = '{0, 0, 32'h100, 32'h0, 32'hE2811001, 0, 32'hE2811001, 2};
        vecs[1] = '{1, 0, 32'h200, 32'h0, 32'h12345678, 1, 32'h12345678, 3};
        vecs[2] = '{1, 1, 32'h40, 32'hDEADBEEF, 32'hFFFF0000, 3, 32'h12345678, 5};
        vecs[3] = '{0, 0, 32'h4, 32'h0, 32'h00000013, 2, 32'h00000013, 4};
        #1;
        check("rst_ctl", {27'd0, bus.mem_req, bus.mem_we, IFValid, DataValidM, BusErr}, 0);
        check("rst_data", InstrF | ReadDataM | bus.mem_addr | bus.mem_wdata, 0);
        repeat (2) @(negedge clk);
        rstN = 1;
        tick();
        check("idle_req", {31'd0, bus.mem_req}, 0);

        foreach (vecs[i]) begin
            tblLat = vecs[i].lat;
            tblRdata = vecs[i].rdata;
            if (vecs[i].isData) begin
                DataReqM = 1; MemWriteM = vecs[i].we;
                ALUResultM = vecs[i].addr; WriteDataM = vecs[i].wdata;
            end else begin
                IFReq = 1; PCF = vecs[i].addr;
            end
            cyc = 0; got = 0;
            while (cyc < 40 && !got) begin
                tick();
                cyc++;
                if (cyc == 1) begin
                    check($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].addr);
                    check($sformatf("v%0d_we", i), {31'd0, bus.mem_we}, {31'd0, vecs[i].we});
                    if (vecs[i].we) check($sformatf("v%0d_wdata", i), bus.mem_wdata, vecs[i].wdata);
                end
                got = vecs[i].isData ? DataValidM : IFValid;
            end
            check($sformatf("v%0d_latency", i), cyc, vecs[i].expCyc);
            check($sformatf("v%0d_data", i), vecs[i].isData ? ReadDataM : InstrF, vecs[i].expData);
            IFReq = 0; DataReqM = 0;
            tick();
            check($sformatf("v%0d_pulse", i), {30'd0, IFValid, DataValidM}, 0);
        end

        // Simultaneous fetch and data read: data first, fetch issued in the data-valid cycle
        tblLat = 0; tblRdata = 32'h0BADF00D;
        IFReq = 1; PCF = 32'h300; DataReqM = 1; MemWriteM = 0; ALUResultM = 32'h200;
        tick();
        check("sim_first", bus.mem_addr, 32'h200);
        tick();
        check("sim_dvalid", {31'd0, DataValidM}, 1);
        tick();
        check("sim_second", {bus.mem_addr[30:0], bus.mem_req}, {31'h300, 1'b1});
        DataReqM = 0;
        tick();
        check("sim_ivalid", {31'd0, IFValid}, 1);
        check("sim_instr", InstrF, 32'h0BADF00D);
        check("sim_rdata", ReadDataM, 32'h0BADF00D);
        IFReq = 0;
        tick();
        check("sim_noextra", {31'd0, bus.mem_req}, 0);

        // Write with three wait cycles: bus held stable, read data untouched
        tblLat = 3; tblRdata = 32'hFFFFFFFF;
        DataReqM = 1; MemWriteM = 1; ALUResultM = 32'h40; WriteDataM = 32'hDEADBEEF;
        reqCyc = 0; dv = 0; stable = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.mem_req) begin
                reqCyc++;
                stable &= bus.mem_addr == 32'h40 && bus.mem_we && bus.mem_wdata == 32'hDEADBEEF;
            end
            if (DataValidM) begin
                dv++;
                DataReqM = 0;
            end
        end
        check("wr_reqcyc", reqCyc, 4);
        check("wr_stable", {31'd0, stable}, 1);
        check("wr_valids", dv, 1);
        check("wr_rdata", ReadDataM, 32'h0BADF00D);

        // Timeout: memory never answers
        memOff = 1;
        DataReqM = 1; MemWriteM = 0; ALUResultM = 32'h80;
        reqCyc = 0; dv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.mem_req) reqCyc++;
            if (DataValidM) begin
                dv++;
                check("to_data", ReadDataM, 0);
                DataReqM = 0;
            end
        end
        check("to_reqcyc", reqCyc, 15);
        check("to_valids", dv, 1);
        check("to_buserr", {31'd0, BusErr}, 1);
        memOff = 0; tblLat = 0; tblRdata = 32'h11;
        IFReq = 1; PCF = 32'h8;
        cyc = 0;
        do begin tick(); cyc++; end while (!IFValid && cyc < 40);
        check("to_after_instr", InstrF, 32'h11);
        check("to_sticky", {31'd0, BusErr}, 1);
        IFReq = 0;
        tick();

        // Asynchronous reset in the middle of a data access
        memOff = 1;
        DataReqM = 1; MemWriteM = 0; ALUResultM = 32'h44;
        tick(); tick();
        check("rm_active", {31'd0, bus.mem_req}, 1);
        #2 rstN = 0;
        #1;
        check("rm_req", {31'd0, bus.mem_req}, 0);
        check("rm_flags", {29'd0, IFValid, DataValidM, BusErr}, 0);
        check("rm_data", InstrF | ReadDataM | bus.mem_addr, 0);
        memOff = 0; tblLat = 0; tblRdata = 32'h77;
        n0 = issued.size();
        @(negedge clk) rstN = 1;
        cyc = 0;
        do begin tick(); cyc++; end while (!DataValidM && cyc < 40);
        check("rm_reissue", lastAddr, 32'h44);
        check("rm_rdata", ReadDataM, 32'h77);
        check("rm_count", issued.size() - n0, 1);
        DataReqM = 0;
        lastRd = 32'h77;
        tick();

        // Back-to-back fetches with IFReq held
        tblRdata = 32'hAB;
        n0 = issued.size();
        IFReq = 1; PCF = 32'h0; nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (IFValid) begin
                nv++;
                if (nv == 1) PCF = 32'h4;
                else IFReq = 0;
            end
        end
        check("b2b_valids", nv, 2);
        check("b2b_issues", issued.size() - n0, 2);
        if (issued.size() - n0 == 2) begin
            check("b2b_first", issued[n0], 32'h0);
            check("b2b_second", issued[n0 + 1], 32'h4);
        end

        // Randomized traffic against the behavioural memory
        tblMode = 0;
        stallChk = 1;
        fork
            begin
                logic [31:0] a;
                int n;
                repeat (60) begin
                    repeat ($urandom_range(0, 2)) tick();
                    a = $urandom_range(0, 63) * 4;
                    IFReq = 1; PCF = a;
                    n = 0;
                    do begin tick(); n++; end while (!IFValid && n < 60);
                    check("rnd_ivalid", {31'd0, IFValid}, 1);
                    check("rnd_iaddr", {lastAddr[31:1], lastWe}, {a[31:1], 1'b0});
                    check("rnd_instr", InstrF, memRd(a));
                    IFReq = 0;
                end
            end
            begin
                logic [31:0] a, d;
                logic w;
                int n;
                repeat (60) begin
                    repeat ($urandom_range(0, 2)) tick();
                    a = $urandom_range(0, 63) * 4;
                    w = 1'($urandom_range(0, 1));
                    d = $urandom;
                    DataReqM = 1; MemWriteM = w; ALUResultM = a; WriteDataM = d;
                    n = 0;
                    do begin tick(); n++; end while (!DataValidM && n < 60);
                    check("rnd_dvalid", {31'd0, DataValidM}, 1);
                    check("rnd_daddr", {lastAddr[31:1], lastWe}, {a[31:1], w});
                    if (w) begin
                        check("rnd_wdata", lastWdata, d);
                        check("rnd_wr_keep", ReadDataM, lastRd);
                    end else begin
                        check("rnd_rdata", ReadDataM, memRd(a));
                        lastRd = memRd(a);
                    end
                    DataReqM = 0;
                end
            end
        join
        stallChk = 0;
        tick();
        check("rnd_buserr", {31'd0, BusErr}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
